// File: rtl/riscv_imm_pkg.sv
// riscv_imm_pkg
//   Shared definitions for the RISC-V immediate generator:
//   - ImmSrc format encodings
//   - base opcode constants used for automatic format decoding
//   - XLEN legality check and the opcode-to-format decode function
package riscv_imm_pkg;

   typedef enum logic [2:0] {
      IMM_I     = 3'b000,
      IMM_S     = 3'b001,
      IMM_B     = 3'b010,
      IMM_J     = 3'b011,
      IMM_U     = 3'b100,
      IMM_SHAMT = 3'b101,
      IMM_RSV6  = 3'b110,
      IMM_RSV7  = 3'b111
   } imm_src_e;

   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;

   function automatic bit xlen_is_legal(input int xlen);
      return (xlen == 32) || (xlen == 64);
   endfunction

   // Unknown opcodes map to a reserved encoding, which the immediate
   // formatter turns into ImmExt=0 / ImmIllegal=1.
   function automatic logic [2:0] auto_src(input logic [31:0] instr);
      logic [2:0] w_src;
      w_src = IMM_RSV7;
      case (instr[6:0])
         OP_LOAD, OP_JALR:  w_src = IMM_I;
         OP_IMM:            w_src = (instr[13:12] == 2'b01) ? IMM_SHAMT : IMM_I;
         OP_STORE:          w_src = IMM_S;
         OP_BRANCH:         w_src = IMM_B;
         OP_JAL:            w_src = IMM_J;
         OP_LUI, OP_AUIPC:  w_src = IMM_U;
         default:           w_src = IMM_RSV7;
      endcase
      return w_src;
   endfunction

endpackage

// File: rtl/imm_sext.sv
// imm_sext
//   Combinational immediate formatter: assembles the immediate field for the
//   selected format and sign-extends it (or zero-extends for SHAMT) to XLEN.
// Ports
//   i_instr   : instruction bits [31:7] (opcode bits are not needed here)
//   i_src     : format select (ImmSrc encoding)
//   o_imm     : extended immediate, XLEN bits
//   o_illegal : format select is reserved
module imm_sext
   import riscv_imm_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic [31:7]     i_instr,
   input  logic [2:0]      i_src,
   output logic [XLEN-1:0] o_imm,
   output logic            o_illegal
);

   // Every format is first built as a signed 32-bit value; the final size
   // cast then extends it to XLEN using Instr[31] as the sign.
   logic signed [31:0] w_raw;

   always_comb begin
      w_raw     = '0;
      o_illegal = 1'b0;
      case (i_src)
         IMM_I:     w_raw = {{20{i_instr[31]}}, i_instr[31:20]};
         IMM_S:     w_raw = {{20{i_instr[31]}}, i_instr[31:25], i_instr[11:7]};
         IMM_B:     w_raw = {{19{i_instr[31]}}, i_instr[31], i_instr[7],
                             i_instr[30:25], i_instr[11:8], 1'b0};
         IMM_J:     w_raw = {{11{i_instr[31]}}, i_instr[31], i_instr[19:12],
                             i_instr[20], i_instr[30:21], 1'b0};
         IMM_U:     w_raw = {i_instr[31:12], 12'b0};
         IMM_SHAMT: w_raw = (XLEN == 64) ? {26'b0, i_instr[25:20]}
                                         : {27'b0, i_instr[24:20]};
         default: begin
            w_raw     = '0;
            o_illegal = 1'b1;
         end
      endcase
   end

   assign o_imm = XLEN'(w_raw);

endmodule

// File: rtl/imm_gen_pipe.sv
// imm_gen_pipe
//   Pipelined RISC-V immediate generator with valid/ready handshaking.
//   One registered output stage backed by a one-entry skid buffer, so the
//   input side's ready is a pure register output.
// Ports
//   clk, rst_n            : clock (rising edge), async active-low reset
//   Instr, ImmSrc         : instruction word and format select
//   in_valid / in_ready   : input handshake
//   Flush                 : drop all held results and any same-cycle input
//   ImmExt, ImmIllegal    : registered result
//   out_valid / out_ready : output handshake
//   IllegalCnt            : saturating count of accepted illegal results
module imm_gen_pipe
   import riscv_imm_pkg::*;
#(
   parameter int XLEN        = 32,
   parameter int AUTO_DECODE = 0
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [31:0]     Instr,
   input  logic [2:0]      ImmSrc,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic            Flush,
   output logic [XLEN-1:0] ImmExt,
   output logic            ImmIllegal,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [7:0]      IllegalCnt
);

   generate
      if (!xlen_is_legal(XLEN)) begin : g_bad_xlen
         $error("imm_gen_pipe: XLEN must be 32 or 64");
      end
   endgenerate

   logic [2:0]      w_src;
   logic [XLEN-1:0] w_imm;
   logic            w_ill;
   logic            w_in_xfer;

   logic            r_out_valid;
   logic [XLEN-1:0] r_out_imm;
   logic            r_out_ill;
   logic            r_skid_full;
   logic [XLEN-1:0] r_skid_imm;
   logic            r_skid_ill;
   logic [7:0]      r_cnt;

   assign w_src = (AUTO_DECODE != 0) ? auto_src(Instr) : ImmSrc;

   imm_sext #(.XLEN(XLEN)) u_imm_sext (
      .i_instr   (Instr[31:7]),
      .i_src     (w_src),
      .o_imm     (w_imm),
      .o_illegal (w_ill)
   );

   assign in_ready  = ~r_skid_full;
   assign w_in_xfer = in_valid & ~r_skid_full;

   // Output register + skid stage
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_out_valid <= 1'b0;
         r_out_imm   <= '0;
         r_out_ill   <= 1'b0;
         r_skid_full <= 1'b0;
         r_skid_imm  <= '0;
         r_skid_ill  <= 1'b0;
         r_cnt       <= 8'd0;
      end else begin
         if (!Flush && w_in_xfer && w_ill && (r_cnt != 8'hFF))
            r_cnt <= r_cnt + 8'd1;

         if (Flush) begin
            r_out_valid <= 1'b0;
            r_skid_full <= 1'b0;
         end else if (r_skid_full) begin
            // Skid is only ever filled behind a valid output, and in_ready=0
            // blocks new input, so the only move is skid -> output.
            if (out_ready) begin
               r_out_imm   <= r_skid_imm;
               r_out_ill   <= r_skid_ill;
               r_skid_full <= 1'b0;
            end
         end else if (w_in_xfer) begin
            if (!r_out_valid || out_ready) begin
               r_out_imm   <= w_imm;
               r_out_ill   <= w_ill;
               r_out_valid <= 1'b1;
            end else begin
               r_skid_imm  <= w_imm;
               r_skid_ill  <= w_ill;
               r_skid_full <= 1'b1;
            end
         end else if (out_ready) begin
            r_out_valid <= 1'b0;
         end
      end
   end

   assign out_valid  = r_out_valid;
   assign ImmExt     = r_out_imm;
   assign ImmIllegal = r_out_ill;
   assign IllegalCnt = r_cnt;

endmodule
